motor_cmd_scheduler: RTL and testbench

MOTOR_CMD_SCHEDULER -- requirements
Module: motor_cmd_scheduler

---
 rtl/motor_cmd_scheduler.sv | 132 +++++++++++++
 tb/tb_motor_cmd_scheduler.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/motor_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : motor_cmd_scheduler
// Purpose  : UART-byte driven scheduler for four H-bridge motors with enforced
//            coast dead-time between drive states, a watchdog and error count.
// Revision : 1.0 - initial release
// ============================================================================
module motor_cmd_scheduler #(
    parameter int DEAD_CYCLES = 50000,
    parameter int WD_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic [7:0] cmd_out,
    output logic [3:0] dead_busy,
    output logic       wd_trip,
    output logic [7:0] err_cnt
);

    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam int WW = (WD_CYCLES > 1) ? $clog2(WD_CYCLES) : 1;
    localparam logic [DW-1:0] c_dead_last = DW'(DEAD_CYCLES - 1);
    localparam logic [WW-1:0] c_wd_last   = WW'(WD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_OFF  = 3'd0,
        S_FWD  = 3'd1,
        S_REV  = 3'd2,
        S_BRK  = 3'd3,
        S_DEAD = 3'd4
    } state_t;

    logic          w_accept;
    logic          w_reject;
    logic          w_wd_expire;
    logic [1:0]    w_req;
    logic [7:0]    w_cmd;
    logic [3:0]    w_busy;
    logic [WW-1:0] r_wd_cnt;
    logic          r_wd_trip;
    logic [7:0]    r_err_cnt;

    assign w_accept    = byte_valid && (byte_in[3:0] == 4'hA);
    assign w_reject    = byte_valid && (byte_in[3:0] != 4'hA);
    assign w_req       = byte_in[5:4];
    // An accepted byte on the expiry cycle keeps the watchdog from tripping.
    assign w_wd_expire = !w_accept && (r_wd_cnt == c_wd_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd_cnt  <= '0;
            r_wd_trip <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            if (w_accept) begin
                r_wd_cnt  <= '0;
                r_wd_trip <= 1'b0;
            end else if (w_wd_expire) begin
                r_wd_trip <= 1'b1;
            end else begin
                r_wd_cnt  <= r_wd_cnt + 1'b1;
            end
            if (w_reject && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    genvar m;
    generate
        for (m = 0; m < 4; m = m + 1) begin : g_motor
            state_t        r_state;
            logic [1:0]    r_pend;
            logic [DW-1:0] r_dcnt;
            logic          w_hit;
            logic          w_dexp;

            assign w_hit  = w_accept && (byte_in[7:6] == 2'(m));
            assign w_dexp = (r_dcnt == c_dead_last);

            always_ff @(posedge clk) begin
                if (reset || w_wd_expire) begin
                    r_state <= S_OFF;
                    r_pend  <= 2'b00;
                    r_dcnt  <= '0;
                end else begin
                    case (r_state)
                        S_OFF: begin
                            if (w_hit) r_state <= state_t'({1'b0, w_req});
                        end
                        S_DEAD: begin
                            if (w_hit && (w_req == 2'b00)) begin
                                r_state <= S_OFF;
                                r_dcnt  <= '0;
                            end else if (w_dexp) begin
                                // A request landing on expiry takes priority over pending.
                                r_state <= state_t'({1'b0, w_hit ? w_req : r_pend});
                                r_dcnt  <= '0;
                            end else begin
                                if (w_hit) r_pend <= w_req;
                                r_dcnt <= r_dcnt + 1'b1;
                            end
                        end
                        default: begin
                            if (w_hit && (w_req != r_state[1:0])) begin
                                if (w_req == 2'b00) begin
                                    r_state <= S_OFF;
                                end else begin
                                    r_state <= S_DEAD;
                                    r_pend  <= w_req;
                                    r_dcnt  <= '0;
                                end
                            end
                        end
                    endcase
                end
            end

            assign w_cmd[2*m +: 2] = (r_state == S_DEAD) ? 2'b00 : r_state[1:0];
            assign w_busy[m]       = (r_state == S_DEAD);
        end
    endgenerate

    assign cmd_out   = w_cmd;
    assign dead_busy = w_busy;
    assign wd_trip   = r_wd_trip;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_motor_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_motor_cmd_scheduler
// Purpose  : Scoreboard bench for motor_cmd_scheduler (DEAD_CYCLES=4, WD_CYCLES=100).
// Revision : 1.0 - initial release
// ============================================================================
module tb_motor_cmd_scheduler;

    logic       clk;
    logic       reset;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic [7:0] cmd_out;
    logic [3:0] dead_busy;
    logic       wd_trip;
    logic [7:0] err_cnt;

    motor_cmd_scheduler #(.DEAD_CYCLES(4), .WD_CYCLES(100)) dut (
        .clk       (clk),
        .reset     (reset),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .cmd_out   (cmd_out),
        .dead_busy (dead_busy),
        .wd_trip   (wd_trip),
        .err_cnt   (err_cnt)
    );

    typedef struct {
        int         cyc;
        string      name;
        logic [7:0] cmd;
        logic [3:0] busy;
        logic       wd;
        logic [7:0] err;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   n_run  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every expectation due on this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_run = n_run + 1;
            if (e.cyc != cyc) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: check for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
            end else if (cmd_out !== e.cmd || dead_busy !== e.busy ||
                         wd_trip !== e.wd || err_cnt !== e.err) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: got cmd=%h busy=%h wd=%b err=%0d, want cmd=%h busy=%h wd=%b err=%0d",
                         e.name, cmd_out, dead_busy, wd_trip, err_cnt,
                         e.cmd, e.busy, e.wd, e.err);
            end
        end
    end

    task automatic expect_at(input int dly, input string name, input logic [7:0] cmd,
                             input logic [3:0] busy, input logic wd, input logic [7:0] err);
        exp_t e;
        e.cyc  = cyc + dly;
        e.name = name;
        e.cmd  = cmd;
        e.busy = busy;
        e.wd   = wd;
        e.err  = err;
        q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        idle(3);
        expect_at(0, "reset_state", 8'h00, 4'h0, 1'b0, 8'd0);
        reset = 1'b0;

        send(8'h5A); expect_at(0, "m1_fwd", 8'h04, 4'h0, 1'b0, 8'd0);
        send(8'h1A); expect_at(0, "m0_fwd", 8'h05, 4'h0, 1'b0, 8'd0);

        // Motor1 FWD -> REV through exactly four dead cycles.
        send(8'h6A);
        for (int i = 0; i < 4; i++) expect_at(i, "dead_window", 8'h01, 4'h2, 1'b0, 8'd0);
        expect_at(4, "dead_to_rev", 8'h09, 4'h0, 1'b0, 8'd0);
        idle(5);

        // OFF request aborts DEAD, no pending drive appears afterwards.
        send(8'h5A); expect_at(0, "rev_to_dead", 8'h01, 4'h2, 1'b0, 8'd0);
        idle(1);
        send(8'h4A);
        expect_at(0, "dead_off", 8'h01, 4'h0, 1'b0, 8'd0);
        expect_at(4, "dead_off_hold", 8'h01, 4'h0, 1'b0, 8'd0);
        idle(5);

        // Pending overwrite keeps the original expiry.
        send(8'h5A); expect_at(0, "off_to_fwd", 8'h05, 4'h0, 1'b0, 8'd0);
        send(8'h6A);
        send(8'h7A);
        for (int i = 0; i < 3; i++) expect_at(i, "dead_overwrite", 8'h01, 4'h2, 1'b0, 8'd0);
        expect_at(3, "dead_to_brk", 8'h0D, 4'h0, 1'b0, 8'd0);
        idle(4);

        // Request on the expiry cycle wins over pending.
        send(8'h5A); expect_at(0, "brk_to_dead", 8'h01, 4'h2, 1'b0, 8'd0);
        idle(3);
        send(8'h6A); expect_at(0, "expiry_request", 8'h09, 4'h0, 1'b0, 8'd0);

        // Bad sync nibble: rejected, counted, saturating; watchdog not fed.
        send(8'h5B); expect_at(0, "bad_byte_1", 8'h09, 4'h0, 1'b0, 8'd1);
        for (int i = 2; i <= 300; i++) begin
            send(8'h5B);
            if (i == 254) expect_at(0, "err_254", 8'h00, 4'h0, 1'b1, 8'd254);
            if (i == 255) expect_at(0, "err_255", 8'h00, 4'h0, 1'b1, 8'd255);
            if (i == 300) expect_at(0, "err_sat", 8'h00, 4'h0, 1'b1, 8'd255);
        end

        send(8'h1A); expect_at(0, "trip_clear", 8'h01, 4'h0, 1'b0, 8'd255);

        // Accepted byte on the would-be expiry cycle prevents the trip.
        send(8'h5A); expect_at(0, "pre_wd", 8'h05, 4'h0, 1'b0, 8'd255);
        idle(99);
        send(8'h9A); expect_at(0, "wd_byte_wins", 8'h15, 4'h0, 1'b0, 8'd255);

        expect_at(99, "wd_not_yet", 8'h15, 4'h0, 1'b0, 8'd255);
        expect_at(100, "wd_trip", 8'h00, 4'h0, 1'b1, 8'd255);
        idle(102);
        send(8'h1A); expect_at(0, "wd_recover", 8'h01, 4'h0, 1'b0, 8'd255);

        // Reset mid-DEAD dominates a concurrent byte and discards pending.
        send(8'h5A);
        send(8'h6A); expect_at(0, "pre_reset_dead", 8'h01, 4'h2, 1'b0, 8'd255);
        reset      = 1'b1;
        byte_in    = 8'h9A;
        byte_valid = 1'b1;
        idle(1);
        expect_at(0, "reset_mid_dead", 8'h00, 4'h0, 1'b0, 8'd0);
        reset      = 1'b0;
        byte_valid = 1'b0;
        expect_at(5, "post_reset", 8'h00, 4'h0, 1'b0, 8'd0);
        idle(7);

        if (q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
